// File: rtl/riscv_alu_mdu.sv
// riscv_alu_mdu: multi-cycle RV32/RV64 integer execute unit, base register-register ALU plus M extension.
// Iterative shift-add multiplier (or single-cycle when FAST_MUL=1) and restoring divider, one bit per cycle.
module riscv_alu_mdu #(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [2:0]      alu_op,
    input  logic [6:0]      alu_op_ext,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res,
    output logic            busy
);
    localparam int SW = $clog2(XLEN);
    localparam int AW = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [2:0]      f3_q, f3_d;
    logic            negq_q, negq_d, negr_q, negr_d;
    logic [XLEN-1:0] res_q, res_d;

    logic            is_m, alt, sa, sb, a_neg, b_neg, div0, ovf;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] mag_a, mag_b, base_res;
    logic [AW-1:0]   ext_a, ext_b, prod;

    assign is_m  = (alu_op_ext == 7'b0000001);
    assign alt   = (alu_op_ext == 7'b0100000);
    // Divides are signed for funct3 100/110; multiplies sign op1 for MULH/MULHSU and op2 for MULH only.
    assign sa    = alu_op[2] ? !alu_op[0] : (alu_op == 3'b001 || alu_op == 3'b010);
    assign sb    = alu_op[2] ? !alu_op[0] : (alu_op == 3'b001);
    assign a_neg = sa && op1[XLEN-1];
    assign b_neg = sb && op2[XLEN-1];
    assign mag_a = a_neg ? -op1 : op1;
    assign mag_b = b_neg ? -op2 : op2;
    assign div0  = (op2 == '0);
    assign ovf   = (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    assign shamt = op2[SW-1:0];
    assign ext_a = a_neg ? {{XLEN{1'b1}}, op1} : {{XLEN{1'b0}}, op1};
    assign ext_b = b_neg ? {{XLEN{1'b1}}, op2} : {{XLEN{1'b0}}, op2};
    assign prod  = ext_a * ext_b;

    always_comb begin
        case (alu_op)
            3'b000:  base_res = alt ? op1 - op2 : op1 + op2;
            3'b001:  base_res = op1 << shamt;
            3'b010:  base_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            3'b011:  base_res = {{(XLEN-1){1'b0}}, op1 < op2};
            3'b100:  base_res = op1 ^ op2;
            3'b101:  base_res = alt ? $unsigned($signed(op1) >>> shamt) : op1 >> shamt;
            3'b110:  base_res = op1 | op2;
            default: base_res = op1 & op2;
        endcase
    end

    // Multiply step: multiplier sits in the low half and shifts out as partial sums shift in from the top.
    logic [XLEN:0]   mul_sum;
    logic [AW-1:0]   mul_nxt, mul_fix;
    assign mul_sum = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
    assign mul_fix = negq_q ? -mul_nxt : mul_nxt;

    // Divide step: partial remainder keeps its carried-out bit so divisors above 2^(XLEN-1) compare correctly.
    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] div_diff;
    logic            div_ge;
    logic [XLEN-1:0] rem_nxt, quo_nxt, quo_fix, rem_fix;
    assign rem_sh   = acc_q[AW-1:XLEN-1];
    assign div_diff = {1'b0, rem_sh} - {2'b00, opb_q};
    assign div_ge   = !div_diff[XLEN+1];
    assign rem_nxt  = div_ge ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_nxt  = {acc_q[XLEN-2:0], div_ge};
    assign quo_fix  = negq_q ? -quo_nxt : quo_nxt;
    assign rem_fix  = negr_q ? -rem_nxt : rem_nxt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        f3_d    = f3_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (in_valid && in_ready) begin
                f3_d   = alu_op;
                cnt_d  = SW'(XLEN - 1);
                negq_d = a_neg ^ b_neg;
                negr_d = a_neg;
                if (!is_m) begin
                    res_d   = base_res;
                    state_d = DONE;
                end else if (!alu_op[2]) begin
                    if (FAST_MUL) begin
                        res_d   = (alu_op == 3'b000) ? prod[XLEN-1:0] : prod[AW-1:XLEN];
                        state_d = DONE;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, mag_b};
                        opb_d   = mag_a;
                        state_d = MUL;
                    end
                end else if (div0) begin
                    res_d   = alu_op[1] ? op1 : '1;
                    state_d = DONE;
                end else if (ovf && !alu_op[0]) begin
                    res_d   = alu_op[1] ? '0 : op1;
                    state_d = DONE;
                end else begin
                    acc_d   = {{XLEN{1'b0}}, mag_a};
                    opb_d   = mag_b;
                    state_d = DIV;
                end
            end
            MUL: begin
                acc_d = mul_nxt;
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == '0) begin
                    res_d   = (f3_q == 3'b000) ? mul_fix[XLEN-1:0] : mul_fix[AW-1:XLEN];
                    state_d = DONE;
                end
            end
            DIV: begin
                acc_d = {rem_nxt, quo_nxt};
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == '0) begin
                    res_d   = f3_q[1] ? rem_fix : quo_fix;
                    state_d = DONE;
                end
            end
            default: if (out_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q  <= acc_d;
        opb_q  <= opb_d;
        f3_q   <= f3_d;
        negq_q <= negq_d;
        negr_q <= negr_d;
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == MUL) || (state_q == DIV);
    assign res       = res_q;
endmodule
